// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npc_pkg
// Purpose  : Shared definitions for the fetch-PC sequencer.
//            - Jump-class codes (j_type)
//            - Branch-class codes (b_type)
//            - Sequencer state encoding
//            - Default reset PC
// Revision : 1.0 - initial release
// ============================================================================
package npc_pkg;

    // Jump class codes. Codes 100..111 decode as "none".
    localparam logic [2:0] c_J_NONE = 3'b000;
    localparam logic [2:0] c_J_J    = 3'b001;
    localparam logic [2:0] c_J_JAL  = 3'b010;
    localparam logic [2:0] c_J_JR   = 3'b011;

    // Branch class codes. Code 111 decodes as "none".
    localparam logic [2:0] c_B_NONE = 3'b000;
    localparam logic [2:0] c_B_BEQ  = 3'b001;
    localparam logic [2:0] c_B_BNE  = 3'b010;
    localparam logic [2:0] c_B_BLEZ = 3'b011;
    localparam logic [2:0] c_B_BGTZ = 3'b100;
    localparam logic [2:0] c_B_BLTZ = 3'b101;
    localparam logic [2:0] c_B_BGEZ = 3'b110;

    // RUN: fetch advancing normally.
    // HOLD: a redirect target is parked until fetch_ready returns.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } npc_state_e;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_3000;

endpackage : npc_pkg
`default_nettype wire

// File: rtl/npc_branch_cmp.sv
`default_nettype none
// ============================================================================
// Module   : npc_branch_cmp
// Purpose  : Combinational branch-condition evaluation.
// Ports    : b_type  in  3   branch class code
//            rs_val  in  32  forwarded rs operand
//            rt_val  in  32  forwarded rt operand
//            taken   out 1   branch condition holds
// Config   : NPC_BRANCH_EXT_EN
//            - defined: blez/bgtz/bltz/bgez are decoded.
//            - undefined: those codes read as "not taken", and only the
//              equality comparator exists.
// Revision : 1.0 - initial release
// ============================================================================
module npc_branch_cmp
    import npc_pkg::*;
(
    input  logic [2:0]  b_type,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        taken
);

    logic w_eq;

    assign w_eq = (rs_val == rt_val);

`ifdef NPC_BRANCH_EXT_EN
    logic w_rs_neg;
    logic w_rs_zero;

    assign w_rs_neg  = rs_val[31];
    assign w_rs_zero = (rs_val == 32'd0);
`endif

    always_comb begin
        taken = 1'b0;
        case (b_type)
            c_B_BEQ:  taken = w_eq;
            c_B_BNE:  taken = !w_eq;
`ifdef NPC_BRANCH_EXT_EN
            c_B_BLEZ: taken = w_rs_neg | w_rs_zero;
            c_B_BGTZ: taken = !w_rs_neg & !w_rs_zero;
            c_B_BLTZ: taken = w_rs_neg;
            c_B_BGEZ: taken = !w_rs_neg;
`endif
            default:  taken = 1'b0;
        endcase
    end

endmodule : npc_branch_cmp
`default_nettype wire

// File: rtl/npc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : npc_sequencer
// Purpose  : Fetch-PC sequencer. Owns the fetch PC, resolves decode-stage
//            branch/jump requests into a redirect target, and parks a
//            redirect that arrives during a fetch stall until fetch resumes.
// Params   : PC_W      PC width, legal 28..32
//            RESET_PC  PC loaded on reset
// Ports    : clk, reset_n               clock, async active-low reset
//            fetch_ready       in  1    imem accepts pc this cycle
//            dec_valid         in  1    D-stage instruction valid
//            dec_pc            in  PC_W PC of the D-stage instruction
//            j_type, b_type    in  3    jump / branch class
//            rs_val, rt_val    in  32   forwarded operands
//            imm16             in  16   branch offset
//            index26           in  26   jump index
//            pc                out PC_W current fetch PC (registered)
//            link_addr         out PC_W dec_pc + 8 (combinational)
//            redirect          out 1    taken redirect (combinational)
//            pend_valid        out 1    redirect parked (registered)
//            collide           out 1    sticky overwrite flag (registered)
//            misalign          out 1    pulse after misaligned redirect
// Config   : NPC_BRANCH_EXT_EN enables blez/bgtz/bltz/bgez decoding.
// Revision : 1.0 - initial release
// ============================================================================
module npc_sequencer
    import npc_pkg::*;
#(
    parameter int unsigned PC_W     = 32,
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_ready,
    input  logic            dec_valid,
    input  logic [PC_W-1:0] dec_pc,
    input  logic [2:0]      j_type,
    input  logic [2:0]      b_type,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    input  logic [15:0]     imm16,
    input  logic [25:0]     index26,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] link_addr,
    output logic            redirect,
    output logic            pend_valid,
    output logic            collide,
    output logic            misalign
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_W-1:0] pc_q,          pc_d;
    logic [PC_W-1:0] pend_target_q, pend_target_d;
    npc_state_e      state_q,       state_d;
    logic            collide_q,     collide_d;
    logic            misalign_q,    misalign_d;

    // ------------------------------------------------------------------
    // Target computation
    // ------------------------------------------------------------------
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_br_offset;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_jmp_target;
    logic [PC_W-1:0] w_target;
    logic            w_is_jump;
    logic            w_br_taken;

    assign w_pc4       = dec_pc + PC_W'(4);
    // Sign-extended word offset; PC_W >= 28 keeps the replication positive.
    assign w_br_offset = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
    assign w_br_target = w_pc4 + w_br_offset;

    // The region bits above the 28-bit jump field only exist for PC_W > 28.
    if (PC_W > 28) begin : g_jmp_region
        assign w_jmp_target = {w_pc4[PC_W-1:28], index26, 2'b00};
    end else begin : g_jmp_flat
        assign w_jmp_target = {index26, 2'b00};
    end

    npc_branch_cmp u_branch_cmp (
        .b_type (b_type),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .taken  (w_br_taken)
    );

    // Jumps take precedence over branches when both classes are non-none.
    always_comb begin
        w_is_jump = (j_type == c_J_J) || (j_type == c_J_JAL) || (j_type == c_J_JR);
        w_target  = w_br_target;
        if (w_is_jump) begin
            w_target = (j_type == c_J_JR) ? rs_val[PC_W-1:0] : w_jmp_target;
        end
    end

    assign redirect  = dec_valid & (w_is_jump | w_br_taken);
    assign link_addr = dec_pc + PC_W'(8);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        state_d       = state_q;
        collide_d     = collide_q;
        misalign_d    = redirect & (w_target[1:0] != 2'b00);

        if (fetch_ready) begin
            state_d = ST_RUN;
            if (redirect) begin
                // A fresh redirect supersedes anything parked.
                pc_d = w_target;
                if (state_q == ST_HOLD) begin
                    collide_d = 1'b1;
                end
            end else if (state_q == ST_HOLD) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_q + PC_W'(4);
            end
        end else if (redirect) begin
            pend_target_d = w_target;
            state_d       = ST_HOLD;
            if (state_q == ST_HOLD) begin
                collide_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC[PC_W-1:0];
            pend_target_q <= '0;
            state_q       <= ST_RUN;
            collide_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            state_q       <= state_d;
            collide_q     <= collide_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc         = pc_q;
    assign pend_valid = (state_q == ST_HOLD);
    assign collide    = collide_q;
    assign misalign   = misalign_q;

endmodule : npc_sequencer
`default_nettype wire
